// File: rtl/reset_pkg.sv
// reset_pkg: shared state type, cause bit positions and helpers for the reset source block
package reset_pkg;

    typedef enum logic [1:0] {RS_IDLE, RS_ASSERT, RS_HOLD} rs_state_t;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_PIN = 1;
    localparam int CAUSE_PLL = 2;
    localparam int CAUSE_SW  = 3;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// reset_debounce: 2-flop synchroniser plus stable-count filter on an asynchronous level
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset
//   d_i      in   asynchronous input level
//   clr_i    in   forces the accepted level back to RESET_LEVEL and clears the counter
//   sync_o   out  synchronised input level
//   level_o  out  accepted level; follows sync_o only after STABLE_CYCLES consecutive disagreeing cycles
module reset_debounce #(
    parameter logic [31:0] STABLE_CYCLES = 32'd8,
    parameter logic        RESET_LEVEL   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    input  logic clr_i,
    output logic sync_o,
    output logic level_o
);

    logic [1:0]  sync_q;
    logic        level_q, level_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (clr_i)
            level_d = RESET_LEVEL;
        else if (sync_q[1] != level_q) begin
            // a single agreeing cycle restarts the count from zero
            if (cnt_q == STABLE_CYCLES - 32'd1)
                level_d = sync_q[1];
            else
                cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= {2{RESET_LEVEL}};
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], d_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_o  = sync_q[1];
    assign level_o = level_q;

endmodule

// File: rtl/reset_source.sv
// reset_source: collects pin, PLL loss-of-lock and software reboot sources into a minimum-width reset_req
//   clock_160    in   system clock
//   async_res    in   power-on reset, asynchronous, active-high
//   inp_resn     in   external RESn pin, asynchronous, active-low
//   pll_en       in   PLL selected as clock source
//   pll_locked   in   PLL lock indicator, asynchronous
//   sw_reboot    in   single-cycle reboot request
//   reset_req    out  registered reset request for the reset filter stage
//   cause        out  sticky {SW,PLL,PIN,POR} bits of the latest reset event
//   reset_count  out  completed reset events since power-on, saturating
module reset_source
    import reset_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES    = 32'd160_000,
    parameter logic [31:0] LOCK_FILTER_CYCLES = 32'd16_000,
    parameter logic [31:0] PULSE_CYCLES       = 32'd1_600
) (
    input  logic       clock_160,
    input  logic       async_res,
    input  logic       inp_resn,
    input  logic       pll_en,
    input  logic       pll_locked,
    input  logic       sw_reboot,
    output logic       reset_req,
    output logic [3:0] cause,
    output logic [7:0] reset_count
);

    logic        pin_level, pin_sync_unused;
    logic        lock_sync, lock_ok;
    logic        pin_req, pll_event;
    logic [3:0]  src;
    rs_state_t   state_q;
    logic [31:0] cnt_q;
    logic [3:0]  cause_q;
    logic [7:0]  count_q;
    logic        req_q;

    reset_debounce #(.STABLE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_pin (
        .clk_i   (clock_160),
        .rst_i   (async_res),
        .d_i     (inp_resn),
        .clr_i   (1'b0),
        .sync_o  (pin_sync_unused),
        .level_o (pin_level)
    );

    // lock_ok drops at once when lock is lost or the PLL is deselected; only the rise is filtered
    reset_debounce #(.STABLE_CYCLES(LOCK_FILTER_CYCLES), .RESET_LEVEL(1'b0)) u_lock (
        .clk_i   (clock_160),
        .rst_i   (async_res),
        .d_i     (pll_locked),
        .clr_i   (~pll_en | ~lock_sync),
        .sync_o  (lock_sync),
        .level_o (lock_ok)
    );

    assign pin_req   = ~pin_level;
    assign pll_event = lock_ok & pll_en & ~lock_sync;

    always_comb begin
        src            = '0;
        src[CAUSE_PIN] = pin_req;
        src[CAUSE_PLL] = pll_event;
        src[CAUSE_SW]  = sw_reboot;
    end

    // reset_req is registered from the next state so it rises on the edge that enters ASSERT
    always_ff @(posedge clock_160 or posedge async_res) begin
        if (async_res) begin
            state_q            <= RS_ASSERT;
            cnt_q              <= PULSE_CYCLES - 32'd1;
            cause_q            <= '0;
            cause_q[CAUSE_POR] <= 1'b1;
            count_q            <= '0;
            req_q              <= 1'b1;
        end else begin
            case (state_q)
                RS_IDLE: if (|src) begin
                    state_q <= RS_ASSERT;
                    cause_q <= src;
                    cnt_q   <= PULSE_CYCLES - 32'd1;
                    count_q <= sat_inc(count_q);
                    req_q   <= 1'b1;
                end
                RS_ASSERT: begin
                    cause_q <= cause_q | src;
                    if (cnt_q == '0)
                        state_q <= RS_HOLD;
                    else
                        cnt_q <= cnt_q - 32'd1;
                end
                RS_HOLD: if (!pin_req) begin
                    state_q <= RS_IDLE;
                    req_q   <= 1'b0;
                end
                default: begin
                    state_q <= RS_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign reset_req   = req_q;
    assign cause       = cause_q;
    assign reset_count = count_q;

endmodule

// File: tb/tb_reset_source.sv
// tb_reset_source: scoreboard bench; expected pulses are queued at stimulus and checked when reset_req falls
module tb_reset_source;

    logic       clock_160 = 1'b0;
    logic       async_res = 1'b0;
    logic       inp_resn  = 1'b1;
    logic       pll_en    = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_reboot = 1'b0;
    logic       reset_req;
    logic [3:0] cause;
    logic [7:0] reset_count;

    typedef struct {
        int         width;
        logic [3:0] cause;
        logic [7:0] count;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t mon_e;
    int     checks = 0;
    int     errors = 0;
    int     width  = 0;
    logic   prev_req = 1'b1;
    int     lat;

    always #5 clock_160 = ~clock_160;

    reset_source #(
        .DEBOUNCE_CYCLES    (32'd8),
        .LOCK_FILTER_CYCLES (32'd4),
        .PULSE_CYCLES       (32'd5)
    ) dut (
        .clock_160   (clock_160),
        .async_res   (async_res),
        .inp_resn    (inp_resn),
        .pll_en      (pll_en),
        .pll_locked  (pll_locked),
        .sw_reboot   (sw_reboot),
        .reset_req   (reset_req),
        .cause       (cause),
        .reset_count (reset_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_pulse(input int w, input logic [3:0] c, input logic [7:0] n);
        pulse_t p;
        p.width = w;
        p.cause = c;
        p.count = n;
        exp_q.push_back(p);
    endtask

    task automatic wait_rise(output int l);
        l = 0;
        do begin
            @(posedge clock_160);
            #1;
            l++;
        end while (!reset_req && l < 100);
    endtask

    task automatic wait_low(input string tag);
        int n = 0;
        while (reset_req && n < 200) begin
            @(posedge clock_160);
            #1;
            n++;
        end
        check(tag, reset_req, 0);
        @(negedge clock_160);
    endtask

    // measures each reset_req pulse in clock edges and scores it on the falling edge
    always @(posedge clock_160) begin
        #1;
        if (async_res)
            width = 0;
        else if (reset_req)
            width++;
        else if (prev_req) begin
            if (exp_q.size() == 0)
                check("unexpected_pulse", exp_q.size(), 1);
            else begin
                mon_e = exp_q.pop_front();
                check("pulse_width", width, mon_e.width);
                check("pulse_cause", cause, mon_e.cause);
                check("pulse_count", reset_count, mon_e.count);
            end
            width = 0;
        end
        prev_req = reset_req;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // power-on reset
        #2 async_res = 1'b1;
        #1;
        check("por_req", reset_req, 1);
        check("por_cause", cause, 4'b0001);
        check("por_count", reset_count, 0);
        @(negedge clock_160);
        @(negedge clock_160);
        async_res = 1'b0;
        expect_pulse(5, 4'b0001, 8'd0);
        wait_low("por_release");
        check("por_count_after", reset_count, 0);

        // pin held low 20 cycles
        inp_resn = 1'b0;
        expect_pulse(20, 4'b0010, 8'd1);
        wait_rise(lat);
        check("pin_latency", lat, 11);
        repeat (10) @(negedge clock_160);
        inp_resn = 1'b1;
        wait_low("pin_release");

        // 7-cycle glitch is filtered
        inp_resn = 1'b0;
        repeat (7) @(negedge clock_160);
        inp_resn = 1'b1;
        repeat (20) @(negedge clock_160);
        check("glitch_no_req", reset_req, 0);
        check("glitch_count", reset_count, 1);

        // PLL enabled but never locked
        pll_en = 1'b1;
        repeat (20) @(negedge clock_160);
        check("pll_unlocked_no_req", reset_req, 0);

        // lock shorter than the filter does not count
        pll_locked = 1'b1;
        repeat (3) @(negedge clock_160);
        pll_locked = 1'b0;
        repeat (10) @(negedge clock_160);
        check("lock_short_no_req", reset_req, 0);

        // lock loss after a filtered lock
        pll_locked = 1'b1;
        repeat (10) @(negedge clock_160);
        pll_locked = 1'b0;
        expect_pulse(6, 4'b0100, 8'd2);
        wait_rise(lat);
        check("pll_latency", lat, 3);
        wait_low("pll_done");

        // deselecting the PLL is not a reset
        pll_locked = 1'b1;
        repeat (10) @(negedge clock_160);
        pll_en = 1'b0;
        repeat (5) @(negedge clock_160);
        pll_locked = 1'b0;
        repeat (10) @(negedge clock_160);
        check("pll_en_fall_no_req", reset_req, 0);
        check("pll_en_fall_count", reset_count, 2);

        // sw_reboot coincident with pll_event, then a second reboot mid-pulse
        pll_en = 1'b1;
        pll_locked = 1'b1;
        repeat (10) @(negedge clock_160);
        pll_locked = 1'b0;
        expect_pulse(6, 4'b1100, 8'd3);
        @(negedge clock_160);
        @(negedge clock_160);
        sw_reboot = 1'b1;
        @(negedge clock_160);
        sw_reboot = 1'b0;
        check("combo_req", reset_req, 1);
        @(negedge clock_160);
        sw_reboot = 1'b1;
        @(negedge clock_160);
        sw_reboot = 1'b0;
        wait_low("combo_done");
        check("combo_count", reset_count, 3);
        pll_en = 1'b0;

        // saturation of the event counter
        for (int i = 0; i < 256; i++) begin
            sw_reboot = 1'b1;
            expect_pulse(6, 4'b1000, (4 + i > 255) ? 8'd255 : 8'(4 + i));
            @(negedge clock_160);
            sw_reboot = 1'b0;
            wait_low("sw_done");
        end
        check("sat_count", reset_count, 255);

        // power-on reset while held in HOLD by the pin
        inp_resn = 1'b0;
        wait_rise(lat);
        check("hold_latency", lat, 11);
        repeat (10) @(negedge clock_160);
        check("hold_req", reset_req, 1);
        check("hold_cause", cause, 4'b0010);
        check("hold_count", reset_count, 255);
        async_res = 1'b1;
        #1;
        check("abort_req", reset_req, 1);
        check("abort_cause", cause, 4'b0001);
        check("abort_count", reset_count, 0);
        inp_resn = 1'b1;
        @(negedge clock_160);
        async_res = 1'b0;
        expect_pulse(5, 4'b0001, 8'd0);
        wait_low("abort_release");
        repeat (5) @(negedge clock_160);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
